// File: rtl/mem_system_ctrl_pkg.sv
// mem_system_ctrl_pkg: shared state encoding, address field layout and timing constants for the cache controller
package mem_system_ctrl_pkg;
  localparam int MEM_LAT  = 2;
  localparam int NWORDS   = 4;
  localparam int TAG_W    = 5;
  localparam int IDX_W    = 8;
  localparam int WORD_W   = $clog2(NWORDS);
  localparam int SETS     = 1 << IDX_W;
  localparam int TAG_LSB  = 11;
  localparam int IDX_LSB  = 3;
  localparam int WORD_LSB = 1;
  // WB and RD states are contiguous so +1 walks WB0..WB3 -> RD0..RD3 -> FILL
  typedef enum logic [3:0] {
    IDLE, COMP, WB0, WB1, WB2, WB3, RD0, RD1, RD2, RD3, FILL, DONE
  } state_t;
  function automatic logic [WORD_W-1:0] st_word(state_t s);
    return WORD_W'(s >= RD0 ? s - RD0 : s - WB0);
  endfunction
endpackage

// File: rtl/mem_system_ctrl_victim_sel.sv
// mem_system_ctrl_victim_sel: replacement way pick, invalid way first, then a global toggle bit or a per-set LRU bit (CTRL_LRU_EN)
module mem_system_ctrl_victim_sel
  import mem_system_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       valid,
  input  logic [IDX_W-1:0] idx,
  input  logic             acc,
  input  logic [1:0]       hit,
  input  logic             fill,
  input  logic             fill_way,
  output logic             victim
);
  logic pick;
`ifdef CTRL_LRU_EN
  logic [SETS-1:0] lru;
  assign pick = lru[idx];
  always_ff @(posedge clk) begin
    if (!rst) lru <= '0;
    else if (acc && |hit) lru[idx] <= hit[0];
    else if (fill) lru[idx] <= ~fill_way;
  end
`else
  logic tgl, unused_lru;
  assign unused_lru = ^{idx, hit, fill, fill_way};
  assign pick = tgl;
  always_ff @(posedge clk) tgl <= !rst ? 1'b0 : tgl ^ acc;
`endif
  assign victim = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : pick;
endmodule

// File: rtl/mem_system_ctrl.sv
// mem_system_ctrl: 2-way set-associative cache controller FSM with write-back and pipelined line fill (CTRL_LRU_EN selects per-set LRU)
module mem_system_ctrl
  import mem_system_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      Addr,
  input  logic [15:0]      DataIn,
  input  logic             Rd,
  input  logic             Wr,
  output logic [15:0]      DataOut,
  output logic             Done,
  output logic             Stall,
  output logic             CacheHit,
  output logic             Err,
  output logic [1:0]       c_en,
  output logic             c_comp,
  output logic             c_write,
  output logic             c_valid_in,
  output logic [TAG_W-1:0] c_tag_out,
  output logic [IDX_W-1:0] c_index,
  output logic [2:0]       c_offset,
  output logic [15:0]      c_data_out,
  input  logic [1:0]       c_hit,
  input  logic [1:0]       c_valid,
  input  logic [1:0]       c_dirty,
  input  logic [TAG_W-1:0] c_tag0,
  input  logic [TAG_W-1:0] c_tag1,
  input  logic [15:0]      c_data0,
  input  logic [15:0]      c_data1,
  output logic [15:0]      m_addr,
  output logic             m_wr,
  output logic             m_rd,
  output logic [15:0]      m_data_out,
  input  logic [15:0]      m_data_in,
  input  logic             m_stall
);
  state_t state;
  logic [TAG_W-1:0] tag_q, vtag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WORD_W-1:0] word_q, k, fk;
  logic [15:0] data_q;
  logic wr_q, vic_q, err_q, vic, vdirty, hit, acc, cmp, in_wb, in_rd, rd_go, fill, unused_addr0;
  logic [MEM_LAT-1:0] pv;
  logic [MEM_LAT-1:0][WORD_W-1:0] pk;
  assign hit = |c_hit;
  assign acc = state == COMP;
  assign cmp = acc || state == DONE;
  assign in_wb = state inside {[WB0:WB3]};
  assign in_rd = state inside {[RD0:RD3]};
  assign rd_go = in_rd && !m_stall;
  assign k = st_word(state);
  assign fill = pv[MEM_LAT-1];
  assign fk = pk[MEM_LAT-1];
  assign vdirty = vic ? c_valid[1] && c_dirty[1] : c_valid[0] && c_dirty[0];
  assign unused_addr0 = Addr[0];
  mem_system_ctrl_victim_sel u_victim_sel (
    .clk      (clk),
    .rst      (rst),
    .valid    (c_valid),
    .idx      (idx_q),
    .acc      (acc),
    .hit      (c_hit),
    .fill     (fill && fk == WORD_W'(NWORDS - 1)),
    .fill_way (vic_q),
    .victim   (vic)
  );
  // pv/pk track accepted reads so each returning word lands at the right offset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      tag_q  <= '0;
      vtag_q <= '0;
      idx_q  <= '0;
      word_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      vic_q  <= 1'b0;
      err_q  <= 1'b0;
      pv     <= '0;
      pk     <= '0;
    end else begin
      err_q <= state == IDLE && Rd && Wr;
      pv    <= {pv[MEM_LAT-2:0], rd_go};
      pk    <= {pk[MEM_LAT-2:0], k};
      case (state)
        IDLE: if (Rd ^ Wr) begin
          state  <= COMP;
          tag_q  <= Addr[TAG_LSB +: TAG_W];
          idx_q  <= Addr[IDX_LSB +: IDX_W];
          word_q <= Addr[WORD_LSB +: WORD_W];
          data_q <= DataIn;
          wr_q   <= Wr;
        end
        COMP: if (hit) state <= IDLE;
        else begin
          vic_q  <= vic;
          vtag_q <= vic ? c_tag1 : c_tag0;
          state  <= vdirty ? WB0 : RD0;
        end
        FILL: if (!(|pv[MEM_LAT-2:0])) state <= DONE;
        DONE: state <= IDLE;
        default: if (!m_stall) state <= state_t'(state + 4'd1);
      endcase
    end
  end
  always_comb begin
    c_en       = fill || in_wb ? (vic_q ? 2'b10 : 2'b01) : cmp ? 2'b11 : 2'b00;
    c_comp     = cmp;
    c_write    = fill || (cmp && wr_q);
    c_valid_in = fill && fk == WORD_W'(NWORDS - 1);
    c_tag_out  = fill || cmp ? tag_q : '0;
    c_index    = fill || cmp || in_wb ? idx_q : '0;
    c_offset   = fill ? {fk, 1'b0} : in_wb ? {k, 1'b0} : cmp ? {word_q, 1'b0} : '0;
    c_data_out = fill ? m_data_in : cmp ? data_q : '0;
    m_wr       = in_wb;
    m_rd       = in_rd;
    m_addr     = in_wb ? {vtag_q, idx_q, k, 1'b0} : in_rd ? {tag_q, idx_q, k, 1'b0} : '0;
    m_data_out = in_wb ? (vic_q ? c_data1 : c_data0) : '0;
    Done       = state == DONE || (acc && hit);
    CacheHit   = acc && hit;
    DataOut    = Done ? (c_hit[1] ? c_data1 : c_data0) : '0;
    Stall      = state != IDLE;
    Err        = err_q;
  end
endmodule
